// File: rtl/prog_sequencer.sv
// Run controller: resets the processor, launches NUM_PROGS programs, times each one.
// Define PROG_SEQ_TIMEOUT_EN to enable the RUN-state watchdog (limit TIMEOUT cycles).
module prog_sequencer #(
    parameter int               NUM_PROGS   = 3,
    parameter int               INIT_CYCLES = 4,
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] TIMEOUT     = 16'hFFFF
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             start,
    output logic             dut_init,
    output logic             dut_req,
    input  logic             dut_ack,
    output logic [3:0]       prog_idx,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             cnt_valid,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

`ifdef PROG_SEQ_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int               IW        = $clog2(INIT_CYCLES + 1);
    localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [IW-1:0]    INIT_ONE  = IW'(1);
    localparam logic [3:0]       LAST_PROG = 4'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_REQ,
        S_BLANK,
        S_RUN,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_init_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done_pend;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_wd_hit;
    logic             w_last;

    // Saturating increment: an all-ones count flags an overflowed program.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_ONE;
    assign w_wd_hit  = WD_EN && (r_cnt == TIMEOUT);
    assign w_last    = (prog_idx == LAST_PROG) || timeout_err;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state     <= S_IDLE;
            r_init_cnt  <= '0;
            r_cnt       <= '0;
            r_done_pend <= 1'b0;
            dut_init    <= 1'b0;
            dut_req     <= 1'b0;
            prog_idx    <= '0;
            cycle_cnt   <= '0;
            cnt_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cnt_valid <= 1'b0;
            dut_req   <= 1'b0;
            unique case (r_state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        r_state     <= S_INIT;
                        r_init_cnt  <= '0;
                        r_cnt       <= '0;
                        r_done_pend <= 1'b0;
                        prog_idx    <= '0;
                        timeout_err <= 1'b0;
                        dut_init    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (r_init_cnt == INIT_LAST) begin
                        r_state  <= S_REQ;
                        dut_init <= 1'b0;
                        dut_req  <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + INIT_ONE;
                    end
                end
                S_REQ: begin
                    r_state <= S_BLANK;
                    r_cnt   <= w_cnt_inc;
                end
                S_BLANK: begin
                    r_state <= S_RUN;
                    r_cnt   <= w_cnt_inc;
                end
                S_RUN: begin
                    // After completion, spend the cnt_valid cycle here before moving on.
                    if (r_done_pend) begin
                        r_done_pend <= 1'b0;
                        if (w_last) begin
                            r_state <= S_FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= S_REQ;
                            prog_idx <= prog_idx + 4'd1;
                            dut_req  <= 1'b1;
                            r_cnt    <= '0;
                        end
                    end else if (dut_ack) begin
                        cycle_cnt   <= w_cnt_inc;
                        cnt_valid   <= 1'b1;
                        r_done_pend <= 1'b1;
                    end else if (w_wd_hit) begin
                        cycle_cnt   <= TIMEOUT;
                        cnt_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                        r_done_pend <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: vector table for a full run plus corner sequences.
// With PROG_SEQ_TIMEOUT_EN a second instance (TIMEOUT=20) exercises the watchdog.
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        init_n = 1'b0;
    logic        start = 1'b0;
    logic        dut_ack = 1'b0;
    logic        dut_init;
    logic        dut_req;
    logic [3:0]  prog_idx;
    logic [15:0] cycle_cnt;
    logic        cnt_valid;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prog_sequencer #(
        .NUM_PROGS(3),
        .INIT_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .init_n(init_n),
        .start(start),
        .dut_init(dut_init),
        .dut_req(dut_req),
        .dut_ack(dut_ack),
        .prog_idx(prog_idx),
        .cycle_cnt(cycle_cnt),
        .cnt_valid(cnt_valid),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

`ifdef PROG_SEQ_TIMEOUT_EN
    logic        wd_start = 1'b0;
    logic        wd_ack = 1'b0;
    logic        wd_init;
    logic        wd_req;
    logic [3:0]  wd_idx;
    logic [15:0] wd_cnt;
    logic        wd_valid;
    logic        wd_busy;
    logic        wd_done;
    logic        wd_terr;

    prog_sequencer #(
        .NUM_PROGS(3),
        .INIT_CYCLES(4),
        .CNT_W(16),
        .TIMEOUT(16'd20)
    ) dut_wd (
        .clk(clk),
        .init_n(init_n),
        .start(wd_start),
        .dut_init(wd_init),
        .dut_req(wd_req),
        .dut_ack(wd_ack),
        .prog_idx(wd_idx),
        .cycle_cnt(wd_cnt),
        .cnt_valid(wd_valid),
        .busy(wd_busy),
        .done(wd_done),
        .timeout_err(wd_terr)
    );
`endif

    // {init, req, idx[3:0], valid, cnt[15:0], busy, done, terr}
    logic [25:0] obs;
    assign obs = {dut_init, dut_req, prog_idx, cnt_valid,
                  cycle_cnt, busy, done, timeout_err};

    typedef struct {
        logic        st;
        logic        ak;
        logic [25:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(logic st, logic ak, logic in, logic rq,
                        logic [3:0] ix, logic v, logic [15:0] c,
                        logic b, logic d);
        vec_t e;
        e.st  = st;
        e.ak  = ak;
        e.exp = {in, rq, ix, v, c, b, d, 1'b0};
        vq.push_back(e);
    endtask

    task automatic wait_req(string nm);
        int k = 0;
        while (!dut_req && k < 40) begin
            tick();
            k++;
        end
        check(nm, {31'd0, dut_req}, 32'd1);
    endtask

    initial begin
        int lens[3];
        logic [15:0] prev;
        lens[0] = 10;
        lens[1] = 3;
        lens[2] = 50;
        prev = 16'd0;

        // Main-run vector table: one row per cycle.
        push(0, 0, 0, 0, 4'd0, 0, 16'd0, 0, 0);
        push(0, 0, 0, 0, 4'd0, 0, 16'd0, 0, 0);
        push(1, 0, 0, 0, 4'd0, 0, 16'd0, 0, 0);
        for (int i = 0; i < 4; i++)
            push(0, 0, 1, 0, 4'd0, 0, 16'd0, 1, 0);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < lens[p]; k++)
                push(0, (k == lens[p] - 1), 0, (k == 0),
                     4'(p), 0, prev, 1, 0);
            prev = 16'(lens[p]);
            push(0, 0, 0, 0, 4'(p), 1, prev, 1, 0);
        end
        for (int i = 0; i < 3; i++)
            push(0, 0, 0, 0, 4'd2, 0, 16'd50, 0, 1);

        // Reset then idle.
        repeat (3) @(posedge clk);
        #1;
        init_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", {6'd0, obs}, 32'd0);
        end

        // Full three-program run from the table.
        for (int i = 0; i < vq.size(); i++) begin
            tick();
            check($sformatf("vec%0d", i), {6'd0, obs}, {6'd0, vq[i].exp});
            start   = vq[i].st;
            dut_ack = vq[i].ak;
        end
        start   = 1'b0;
        dut_ack = 1'b0;

        // Restart from FINISH; stale ack across REQ/BLANK; start mid-RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_init", {31'd0, dut_init}, 32'd1);
        check("restart_idx", {28'd0, prog_idx}, 32'd0);
        check("restart_done", {31'd0, done}, 32'd0);
        check("cnt_hold", {16'd0, cycle_cnt}, 32'd50);
        wait_req("stale_req0");
        tick();
        tick();
        dut_ack = 1'b1;
        tick();
        check("stale_v0", {15'd0, cnt_valid, cycle_cnt}, {15'd0, 1'b1, 16'd3});
        tick();
        check("stale_req1", {27'd0, dut_req, prog_idx}, {27'd0, 1'b1, 4'd1});
        tick();
        dut_ack = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start   = 1'b0;
        dut_ack = 1'b1;
        tick();
        dut_ack = 1'b0;
        check("stale_v1", {15'd0, cnt_valid, cycle_cnt}, {15'd0, 1'b1, 16'd5});
        check("midrun_start_idx", {28'd0, prog_idx}, 32'd1);
        wait_req("stale_req2");
        check("req2_idx", {28'd0, prog_idx}, 32'd2);
        repeat (5) tick();
        dut_ack = 1'b1;
        tick();
        dut_ack = 1'b0;
        check("v2", {15'd0, cnt_valid, cycle_cnt}, {15'd0, 1'b1, 16'd6});
        tick();
        check("done2", {30'd0, done, busy}, {30'd0, 1'b1, 1'b0});

        // Asynchronous reset mid-RUN of program 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_req("ar_req0");
        tick();
        tick();
        dut_ack = 1'b1;
        tick();
        dut_ack = 1'b0;
        tick();
        check("ar_req1", {27'd0, dut_req, prog_idx}, {27'd0, 1'b1, 4'd1});
        tick();
        tick();
        dut_ack = 1'b1;
        #3;
        init_n = 1'b0;
        #1;
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_req", {31'd0, dut_req}, 32'd0);
        check("ar_idx", {28'd0, prog_idx}, 32'd0);
        tick();
        init_n  = 1'b1;
        dut_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ar_quiet", {30'd0, cnt_valid, busy}, 32'd0);
        end

        // No ack: run still busy after 1000 cycles (default TIMEOUT not reached).
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_req("hang_req");
        repeat (1000) tick();
        check("hang_busy", {30'd0, busy, timeout_err}, {30'd0, 1'b1, 1'b0});

`ifdef PROG_SEQ_TIMEOUT_EN
        begin
            int k = 0;
            int reqs = 0;
            wd_start = 1'b1;
            tick();
            wd_start = 1'b0;
            while (!wd_valid && k < 200) begin
                tick();
                k++;
            end
            check("wd_valid", {31'd0, wd_valid}, 32'd1);
            check("wd_cnt", {16'd0, wd_cnt}, 32'd20);
            check("wd_terr", {31'd0, wd_terr}, 32'd1);
            tick();
            check("wd_done", {30'd0, wd_done, wd_busy}, {30'd0, 1'b1, 1'b0});
            for (int i = 0; i < 30; i++) begin
                if (wd_req) reqs++;
                tick();
            end
            check("wd_no_req", reqs, 32'd0);
            check("wd_idx", {28'd0, wd_idx}, 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller that sits directly upstream of the processor top level and drives its `init`/`req` inputs while consuming its `ack` output. On a `start` pulse it resets the processor, then launches `NUM_PROGS` programs back-to-back. It times each program in clock cycles and reports each count, and optionally aborts a hung program with a watchdog. It replaces hand-driven init/req sequencing in the bench and in board bring-up.

## Interface
- `NUM_PROGS`, default 3: programs per run, valid range 1..15.
- `INIT_CYCLES`, default 4: cycles `dut_init` is held high, at least 1.
- `CNT_W`, default 16: width of the cycle counter.
- `TIMEOUT`, default 16'hFFFF: watchdog limit in cycles. Only used when `PROG_SEQ_TIMEOUT_EN` is defined.
- `clk` input 1: clock; all flops are posedge.
- `init_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a run. Ignored unless the block is in IDLE or FINISH.
- `dut_init` output 1: drives processor `init`, active high.
- `dut_req` output 1: drives processor `req`.
- `dut_ack` input 1: processor `ack`.
- `prog_idx` output 4: index of the current program, 0-based.
- `cycle_cnt` output CNT_W: cycles the last program took. Holds until the next program completes.
- `cnt_valid` output 1: one-cycle pulse when `cycle_cnt` updates.
- `busy` output 1: high in every state except IDLE and FINISH.
- `done` output 1: high in FINISH.
- `timeout_err` output 1: sticky watchdog flag, cleared by `start` or reset.

## Operation
- States: IDLE, INIT, REQ, BLANK, RUN, FINISH.
- IDLE, on `start`: go to INIT. Clear `prog_idx`, `timeout_err`, the internal counter and the INIT cycle counter.
- INIT: `dut_init`=1 for exactly INIT_CYCLES cycles, then go to REQ.
- REQ: `dut_req`=1 for exactly one cycle. Clear the internal counter to 0. Go to BLANK.
- BLANK: one cycle in which `dut_ack` is ignored, because a stale ack from the previous program may still be high. The counter increments. Go to RUN.
- RUN: the counter increments each cycle. On `dut_ack`=1:
  - `cycle_cnt` <= counter + 1, which is the cycle count from the req cycle up to and including the ack cycle.
  - Pulse `cnt_valid`.
  - If `prog_idx`==NUM_PROGS-1, go to FINISH.
  - Otherwise increment `prog_idx` and go to REQ.
- FINISH: `done`=1. On `start`, go to INIT as in IDLE. There is no re-init between programs within a run; only a new `start` re-inits.
- Counter width: the counter saturates at all-ones and never wraps. A saturated `cycle_cnt` means the program overflowed the counter.
- `dut_init` and `dut_req` are never high in the same cycle.
- `start` arriving while busy is dropped; it is not queued.

## Timing
- Reset (`init_n`=0, asynchronous): go to IDLE immediately. All outputs go to 0: `dut_init`, `dut_req`, `prog_idx`, `cycle_cnt`, `cnt_valid`, `busy`, `done`, `timeout_err`.
- Reset mid-run: the run is abandoned. No `cnt_valid` pulse is emitted. After release the block waits for `start`.
- All outputs are registered; there is no combinational path from `dut_ack` to any output.
- `start` sampled in cycle t gives `dut_init`=1 from t+1 through t+INIT_CYCLES.
- `dut_req` is high in cycle t+INIT_CYCLES+1.
- Minimum program: ack seen in the first RUN cycle, which is 2 cycles after REQ. This gives `cycle_cnt`=3, with `cnt_valid` in the following cycle.
- Program to next program: the REQ cycle immediately follows the `cnt_valid` cycle.
- `dut_ack` arriving in the REQ or BLANK cycle is ignored. If ack is still high on entering RUN, it counts as completion.

## Configuration
- `PROG_SEQ_TIMEOUT_EN` defined:
  - In RUN, when the counter reaches TIMEOUT without `dut_ack`, set `timeout_err`=1 and pulse `cnt_valid` with `cycle_cnt`=TIMEOUT.
  - Then go to FINISH without running the remaining programs.
- `PROG_SEQ_TIMEOUT_EN` undefined:
  - No watchdog; RUN waits forever.
  - `timeout_err` is tied to 0.
  - The TIMEOUT parameter is unused.

## Test plan
- Reset then idle: `init_n` low for 3 cycles, then high, no `start` -> all outputs 0 for 20 cycles and `busy`=0.
- Single run, NUM_PROGS=3, INIT_CYCLES=4, model ack after 10/3/50 cycles -> `dut_init` high exactly 4 cycles, three `dut_req` pulses, `cycle_cnt`=10, 3, 50 with three `cnt_valid` pulses, `prog_idx` 0→1→2, then `done`=1.
- Stale ack: hold `dut_ack`=1 through REQ and BLANK after program 0, then drop it, then assert 5 cycles after req -> program 1 reports `cycle_cnt`=5, not 3.
- `start` pulsed mid-RUN -> ignored, the run completes normally. `start` in FINISH -> new INIT and `prog_idx`=0.
- Async reset asserted mid-RUN, between clock edges -> `busy`, `dut_req` and `prog_idx` drop to 0 before the next edge, and no `cnt_valid` pulse follows.
- With `PROG_SEQ_TIMEOUT_EN`, TIMEOUT=20, ack never arrives -> `cnt_valid` with `cycle_cnt`=20, `timeout_err`=1, `done`=1, and no further `dut_req`. Without the macro -> `busy` stays 1 after 1000 cycles.
